// File: rtl/error_checking_pkg.sv
// Shared definitions for the OBC challenge scheduler: FSM encoding, LFSR seed,
// default parameter values and the expected-answer rule.
package error_checking_pkg;

    localparam int unsigned ROUND_LEN_DEF       = 10;
    localparam int unsigned PASS_THRESHOLD_DEF  = 7;
    localparam int unsigned MAX_FAIL_ROUNDS_DEF = 3;
    localparam int unsigned TIMEOUT_CYCLES_DEF  = 255;

    localparam int unsigned Q_W     = 4;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned FAIL_W  = 2;
    localparam int unsigned TIMER_W = 8;

    localparam logic [Q_W-1:0] LFSR_SEED = 4'b0001;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT     = 3'd2,
        EVAL     = 3'd3,
        SHUTDOWN = 3'd4
    } sched_state_e;

    // Answer the OBC must return for a given challenge.
    function automatic logic [Q_W-1:0] expected_answer(input logic [Q_W-1:0] q);
        return {q[2] ^ q[3], q[1] ^ q[2], q[0] ^ q[1], ~q[0]};
    endfunction

endpackage

// File: rtl/challenge_lfsr.sv
// 4-bit Fibonacci LFSR (period 15) producing challenge questions; steps only
// on the advance strobe so the sequence persists across rounds.
module challenge_lfsr
    import error_checking_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           advance,
    output logic [Q_W-1:0] value
);

    // Shift left, feeding back q[3]^q[2]; seed keeps the register off zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= {value[2:0], value[3] ^ value[2]};
        end
    end

endmodule

// File: rtl/obc_challenge_scheduler.sv
// OBC challenge scheduler: issues LFSR challenges, scores the OBC's answers per
// round, pulses round_pass / obc_reset, and latches override after too many
// consecutive failed rounds.
// Optional feature: define CHALLENGE_TIMEOUT_EN to add a WAIT-state answer
// timeout (a missing answer is scored as wrong).
module obc_challenge_scheduler
    import error_checking_pkg::*;
#(
    parameter int unsigned ROUND_LEN       = ROUND_LEN_DEF,
    parameter int unsigned PASS_THRESHOLD  = PASS_THRESHOLD_DEF,
    parameter int unsigned MAX_FAIL_ROUNDS = MAX_FAIL_ROUNDS_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [Q_W-1:0]    question,
    output logic              q_valid,
    input  logic [Q_W-1:0]    answerOBC,
    input  logic              a_valid,
    output logic              round_pass,
    output logic              obc_reset,
    output logic              override,
    output logic [FAIL_W-1:0] fail_count
);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  correct_q, correct_d;
    logic [FAIL_W-1:0] fail_d;
    logic [Q_W-1:0]    question_d;
    logic              pass_d;
    logic              fail_pulse_d;
    logic              lfsr_adv_c;
    logic [Q_W-1:0]    lfsr_value;
    logic              answer_ok_c;
    logic              timeout_c;

    challenge_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (lfsr_adv_c),
        .value   (lfsr_value)
    );

    assign answer_ok_c = (answerOBC == expected_answer(question));

`ifdef CHALLENGE_TIMEOUT_EN
    logic [TIMER_W-1:0] timer_q, timer_d;

    // Timer holds the number of WAIT cycles already elapsed, so the timeout
    // fires in the TIMEOUT_CYCLES-th WAIT cycle.
    assign timeout_c = (state_q == WAIT) &&
                       (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // WAIT timer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    // No timer in this build: WAIT holds until an answer arrives.
    assign timeout_c = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // State, round bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            correct_q  <= '0;
            question   <= '0;
            q_valid    <= 1'b0;
            round_pass <= 1'b0;
            obc_reset  <= 1'b0;
            override   <= 1'b0;
            fail_count <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            correct_q  <= correct_d;
            question   <= question_d;
            q_valid    <= (state_d == WAIT);
            round_pass <= pass_d;
            obc_reset  <= fail_pulse_d;
            override   <= (state_d == SHUTDOWN);
            fail_count <= fail_d;
        end
    end

    // Next-state and round scoring; enable low aborts any active round.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        correct_d    = correct_q;
        fail_d       = fail_count;
        question_d   = question;
        pass_d       = 1'b0;
        fail_pulse_d = 1'b0;
        lfsr_adv_c   = 1'b0;
`ifdef CHALLENGE_TIMEOUT_EN
        timer_d      = timer_q;
`endif

        case (state_q)
            IDLE: begin
                idx_d     = '0;
                correct_d = '0;
                if (enable) begin
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    question_d = lfsr_value;
                    lfsr_adv_c = 1'b1;
                    state_d    = WAIT;
`ifdef CHALLENGE_TIMEOUT_EN
                    timer_d    = '0;
`endif
                end
            end

            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (a_valid || timeout_c) begin
                    if (a_valid && answer_ok_c && (correct_q < IDX_W'(ROUND_LEN))) begin
                        correct_d = correct_q + IDX_W'(1);
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if ((idx_q + IDX_W'(1)) == IDX_W'(ROUND_LEN)) begin
                        state_d = EVAL;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
`ifdef CHALLENGE_TIMEOUT_EN
                    timer_d = timer_q + TIMER_W'(1);
`endif
                end
            end

            EVAL: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (correct_q >= IDX_W'(PASS_THRESHOLD)) begin
                    pass_d  = 1'b1;
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    fail_pulse_d = 1'b1;
                    fail_d       = fail_count + FAIL_W'(1);
                    if ((fail_count + FAIL_W'(1)) == FAIL_W'(MAX_FAIL_ROUNDS)) begin
                        state_d = SHUTDOWN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            SHUTDOWN: begin
                state_d = SHUTDOWN;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_obc_challenge_scheduler.sv
// Scoreboard bench for obc_challenge_scheduler: the driver predicts questions and
// round outcomes from a behavioural model and queues them; a monitor pops and
// compares whenever the DUT presents a question or a round pulse.
module tb_obc_challenge_scheduler;

    localparam int unsigned ROUND_LEN       = 10;
    localparam int unsigned PASS_THRESHOLD  = 7;
    localparam int unsigned MAX_FAIL_ROUNDS = 3;
    localparam int unsigned TIMEOUT_CYCLES  = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] answerOBC = 4'd0;
    logic       a_valid = 1'b0;
    logic [3:0] question;
    logic       q_valid;
    logic       round_pass;
    logic       obc_reset;
    logic       override;
    logic [1:0] fail_count;

    always #5 clk = ~clk;

    obc_challenge_scheduler #(
        .ROUND_LEN       (ROUND_LEN),
        .PASS_THRESHOLD  (PASS_THRESHOLD),
        .MAX_FAIL_ROUNDS (MAX_FAIL_ROUNDS),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .question   (question),
        .q_valid    (q_valid),
        .answerOBC  (answerOBC),
        .a_valid    (a_valid),
        .round_pass (round_pass),
        .obc_reset  (obc_reset),
        .override   (override),
        .fail_count (fail_count)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] q_exp[$];
    logic [4:0] r_exp[$];

    int m_lfsr;
    int m_fail;
    int m_correct;

    // Reference LFSR step: shift left in 4 bits, append bit3 xor bit2.
    function automatic int ref_next(input int s);
        return ((s * 2) % 16) + (((s / 8) + (s / 4)) % 2);
    endfunction

    // Reference answer: bit0 = not q0, bit i = q(i-1) xor q(i).
    function automatic int ref_answer(input int q);
        int b[4];
        int r;
        for (int i = 0; i < 4; i++) b[i] = (q >> i) % 2;
        r = 1 - b[0];
        for (int i = 1; i < 4; i++) r += ((b[i - 1] + b[i]) % 2) << i;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name, input int act, input int exp);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Monitor: compares presented questions and round pulses with the queues.
    initial begin
        logic qv_prev;
        logic pulse_prev;
        logic pulse;
        qv_prev = 1'b0;
        pulse_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                qv_prev = 1'b0;
                pulse_prev = 1'b0;
            end else begin
                if (q_valid && !qv_prev) begin
                    if (q_exp.size() == 0) report_fail("unexpected_question", int'(question), -1);
                    else check("question", int'(question), int'(q_exp.pop_front()));
                end
                pulse = round_pass | obc_reset;
                if (pulse) begin
                    check("pulse_width_prev", int'(pulse_prev), 0);
                    if (r_exp.size() == 0)
                        report_fail("unexpected_pulse", int'({round_pass, obc_reset, fail_count, override}), -1);
                    else
                        check("round_outcome", int'({round_pass, obc_reset, fail_count, override}),
                              int'(r_exp.pop_front()));
                end
                qv_prev = q_valid;
                pulse_prev = pulse;
            end
        end
    end

    // Global watchdog.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_qvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            report_fail("q_valid_wait", 0, 1);
            finish_run();
        end
    endtask

    // One question: predict it, then answer right/wrong, late, or not at all.
    task automatic do_question(input bit wrong, input bit skip, input bit late);
        int  q;
        int  a;
        int  cnt;
        bit  ok;
        q = m_lfsr;
        q_exp.push_back(4'(q));
        m_lfsr = ref_next(m_lfsr);
        wait_qvalid(ok);
        if (!ok) return;
        if (skip) begin
            cnt = 0;
            while (q_valid && cnt < 400) begin
                cnt++;
                @(negedge clk);
            end
            check("timeout_wait_cycles", cnt, int'(TIMEOUT_CYCLES));
        end else begin
            if (late) repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
            else repeat ($urandom_range(0, 3)) @(negedge clk);
            a = ref_answer(q);
            if (wrong) a = a ^ int'($urandom_range(1, 15));
            answerOBC = 4'(a);
            a_valid = 1'b1;
            @(negedge clk);
            a_valid = 1'b0;
            answerOBC = 4'($urandom);
            if (!wrong) m_correct++;
        end
    endtask

    // Full round; queues the predicted outcome pulse.
    task automatic run_round(input logic [15:0] wrong_mask, input logic [15:0] skip_mask,
                             input logic [15:0] late_mask);
        m_correct = 0;
        for (int i = 0; i < int'(ROUND_LEN); i++)
            do_question(wrong_mask[i], skip_mask[i], late_mask[i]);
        if (m_correct >= int'(PASS_THRESHOLD)) begin
            m_fail = 0;
            r_exp.push_back({1'b1, 1'b0, 2'b00, 1'b0});
        end else begin
            m_fail++;
            r_exp.push_back({1'b0, 1'b1, 2'(m_fail), 1'(m_fail == int'(MAX_FAIL_ROUNDS))});
        end
    endtask

    // Answer n questions, then drop enable while the next one is in WAIT.
    task automatic drop_round(input int n);
        bit ok;
        for (int i = 0; i < n; i++) do_question(1'b0, 1'b0, 1'b0);
        q_exp.push_back(4'(m_lfsr));
        m_lfsr = ref_next(m_lfsr);
        wait_qvalid(ok);
        if (!ok) return;
        enable = 1'b0;
        @(negedge clk);
        check("drop_q_valid", int'(q_valid), 0);
        repeat (4) @(negedge clk);
        check("drop_fail_count", int'(fail_count), m_fail);
        enable = 1'b1;
    endtask

    function automatic logic [15:0] make_mask(input int n);
        logic [15:0] m;
        m = '0;
        while ($countones(m) < n) m[$urandom_range(0, ROUND_LEN - 1)] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [15:0] m;
        repeat (3) @(negedge clk);
        check("reset_q_valid", int'(q_valid), 0);
        check("reset_question", int'(question), 0);
        check("reset_round_pass", int'(round_pass), 0);
        check("reset_obc_reset", int'(obc_reset), 0);
        check("reset_override", int'(override), 0);
        check("reset_fail_count", int'(fail_count), 0);

        reset = 1'b1;
        m_lfsr = 1;
        m_fail = 0;
        // Stray answers while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'($urandom);
            answerOBC = 4'($urandom);
            @(negedge clk);
            check("idle_q_valid", int'(q_valid), 0);
        end
        a_valid = 1'b0;
        enable = 1'b1;

        run_round(16'h0000, 16'h0000, 16'h0000);
        run_round(make_mask(3), 16'h0000, 16'h0000);
        run_round(make_mask(int'($urandom_range(0, 2))), 16'h0000, 16'h0000);
        run_round(make_mask(4), 16'h0000, 16'h0000);
        drop_round(5);
        run_round(make_mask(int'($urandom_range(4, 10))), 16'h0000, 16'h0000);
        run_round(make_mask(1), 16'h0000, 16'h0000);

`ifdef CHALLENGE_TIMEOUT_EN
        // Q0 times out (wrong), Q1 answered in the timeout cycle (counted),
        // two more wrong: exactly PASS_THRESHOLD correct.
        m = '0;
        while ($countones(m) < 2) m[$urandom_range(2, ROUND_LEN - 1)] = 1'b1;
        run_round(m, 16'h0001, 16'h0002);
`else
        m = make_mask(int'($urandom_range(0, 3)));
        run_round(m, 16'h0000, 16'h0000);
`endif

        for (int k = 0; k < int'(MAX_FAIL_ROUNDS); k++)
            run_round(make_mask(int'($urandom_range(4, 10))), 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        check("shutdown_fail_count", int'(fail_count), int'(MAX_FAIL_ROUNDS));
        for (int i = 0; i < 20; i++) begin
            a_valid = 1'($urandom);
            answerOBC = 4'($urandom);
            @(negedge clk);
            check("shutdown_q_valid", int'(q_valid), 0);
            check("shutdown_override", int'(override), 1);
        end
        a_valid = 1'b0;

        // Asynchronous reset out of SHUTDOWN.
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_override", int'(override), 0);
        check("rst_fail_count", int'(fail_count), 0);
        check("rst_q_valid", int'(q_valid), 0);
        @(negedge clk);
        reset = 1'b1;
        m_lfsr = 1;
        m_fail = 0;
        run_round(make_mask(int'($urandom_range(0, 3))), 16'h0000, 16'h0000);
        @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);

        check("q_exp_drained", q_exp.size(), 0);
        check("r_exp_drained", r_exp.size(), 0);
        finish_run();
    end

endmodule
